// File: rtl/mx_pkg.sv
// mx_pkg: shared state encoding, default sizes and select-validity helper for mxn_pipe.
package mx_pkg;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_NCH = 4;
  function automatic logic sel_ok(input int unsigned sel, input int unsigned nch);
    return sel < nch;
  endfunction
endpackage

// File: rtl/mxn_comb.sv
// mxn_comb: combinational NCH:1 WIDTH-bit mux, zero on out-of-range select.
module mxn_comb #(
  parameter int WIDTH = 64,
  parameter int NCH = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] data,
  output logic [WIDTH-1:0]     y
);
  always_comb begin
    y = '0;
    for (int k = 0; k < NCH; k++)
      if (sel == SELW'(k)) y = data[k*WIDTH +: WIDTH];
  end
endmodule

// File: rtl/mxn_pipe.sv
// mxn_pipe: registered NCH:1 operand mux with valid/ready handshake and a two-entry skid buffer.
module mxn_pipe
  import mx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH = DEF_NCH,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SELW-1:0]      in_sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 err_sel,
  input  logic                 clear_err
);
  state_t state, nxt;
  logic [WIDTH-1:0] cap_data, skid_data;
  logic [SELW-1:0] skid_sel;
  logic accept, emit;
  mxn_comb #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) u_mux (
    .sel(in_sel),
    .data(in_data),
    .y(cap_data)
  );
  // in_ready is registered low in FULL, so accept can never fire there
  assign accept = in_valid && in_ready;
  assign emit = out_valid && out_ready;
  always_comb begin
    nxt = state == ST_EMPTY ? (accept ? ST_ONE : ST_EMPTY) :
          state == ST_ONE   ? (accept && !emit ? ST_FULL : !accept && emit ? ST_EMPTY : ST_ONE) :
                              (emit ? ST_ONE : ST_FULL);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready <= 1'b1;
      out_data <= '0;
      out_sel <= '0;
      skid_data <= '0;
      skid_sel <= '0;
      err_sel <= 1'b0;
    end else begin
      state <= nxt;
      out_valid <= nxt != ST_EMPTY;
      in_ready <= nxt != ST_FULL;
      if (state == ST_FULL) begin
        if (emit) begin
          out_data <= skid_data;
          out_sel <= skid_sel;
        end
      end else if (accept && (state == ST_EMPTY || emit)) begin
        out_data <= cap_data;
        out_sel <= in_sel;
      end else if (accept) begin
        skid_data <= cap_data;
        skid_sel <= in_sel;
      end
      if (clear_err) err_sel <= 1'b0;
      else if (accept && !sel_ok(32'(in_sel), NCH)) err_sel <= 1'b1;
    end
  end
endmodule
